// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single off-chip memory port between the I-cache (line reads
// only) and the D-cache (line reads and write-backs). One transaction is
// served at a time. Simultaneous requests alternate: the requester that was
// not granted last time wins. Every memory-side output is registered, and
// each requester has a saturating completed-transaction counter.
//
// Ports:
//   clk, rst_n                 system clock (rising edge), async active-low reset
//   i_mem_read, i_mem_addr     I-cache line read request and address
//   i_mem_rdata, i_mem_ready   line returned to the I-cache, one-cycle done pulse
//   d_mem_read, d_mem_write    D-cache line read / write-back requests
//   d_mem_addr, d_mem_wdata    D-cache line address and write-back data
//   d_mem_rdata, d_mem_ready   line returned to the D-cache, one-cycle done pulse
//   mem_read, mem_write        memory strobes, held until mem_ready
//   mem_addr, mem_wdata        memory address and write data
//   mem_rdata, mem_ready       memory read data and completion
//   owner                      00 none, 01 I-cache, 10 D-cache
//   i_cnt, d_cnt               saturating completed-transaction counters
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_mem_read,
   input  logic [ADDR_W-1:0] i_mem_addr,
   output logic [DATA_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wdata,
   output logic [DATA_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        owner,
   output logic [CNT_W-1:0]  i_cnt,
   output logic [CNT_W-1:0]  d_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   // Round-robin pointer: 1 when the D-cache was granted last.
   logic last_d;
   logic pend_i;
   logic pend_d;
   logic grant_i;
   logic grant_d;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration and next state. On a tie the requester that was not
   // granted last wins; the grant terms are only acted upon in IDLE.
   always_comb begin
      pend_i    = i_mem_read;
      pend_d    = d_mem_read | d_mem_write;
      grant_d   = pend_d & (~pend_i | ~last_d);
      grant_i   = pend_i & (~pend_d | last_d);
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_nxt = SERVE_D;
            end else if (grant_i) begin
               state_nxt = SERVE_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_ready) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered datapath. The request is latched on the grant edge so later
   // changes on the cache-side inputs cannot disturb the transaction. A
   // write-back wins over a read when the D-cache raises both. The strobe
   // register doubles as the operation type while serving, which is how a
   // write completion is kept from overwriting d_mem_rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         i_mem_rdata <= '0;
         d_mem_rdata <= '0;
         i_mem_ready <= 1'b0;
         d_mem_ready <= 1'b0;
         owner       <= 2'b00;
         i_cnt       <= '0;
         d_cnt       <= '0;
         last_d      <= 1'b0;
      end else begin
         i_mem_ready <= 1'b0;
         d_mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  mem_addr  <= d_mem_addr;
                  mem_wdata <= d_mem_wdata;
                  mem_write <= d_mem_write;
                  mem_read  <= ~d_mem_write;
                  owner     <= 2'b10;
                  last_d    <= 1'b1;
               end else if (grant_i) begin
                  mem_addr  <= i_mem_addr;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  owner     <= 2'b01;
                  last_d    <= 1'b0;
               end
            end
            SERVE_I: begin
               if (mem_ready) begin
                  mem_read    <= 1'b0;
                  mem_write   <= 1'b0;
                  i_mem_rdata <= mem_rdata;
                  i_mem_ready <= 1'b1;
                  if (i_cnt != '1) begin
                     i_cnt <= i_cnt + 1'b1;
                  end
               end
            end
            SERVE_D: begin
               if (mem_ready) begin
                  mem_read    <= 1'b0;
                  mem_write   <= 1'b0;
                  if (mem_read) begin
                     d_mem_rdata <= mem_rdata;
                  end
                  d_mem_ready <= 1'b1;
                  if (d_cnt != '1) begin
                     d_cnt <= d_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               owner <= 2'b00;
            end
            default: begin
               owner <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. Each request pushes its expected
// transaction (requester, op, address, data, returned line) onto a queue in
// the order the arbitration rules predict; the memory responder pops the
// head when the arbiter raises a strobe and checks the whole transaction
// through to its completion pulse, counters and returned data.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int CNT_W  = 16;

   typedef struct {
      logic              who;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
   } txn_t;

   logic              clk;
   logic              rst_n;
   logic              iMemRead;
   logic [ADDR_W-1:0] iMemAddr;
   logic [DATA_W-1:0] iMemRdata;
   logic              iMemReady;
   logic              dMemRead;
   logic              dMemWrite;
   logic [ADDR_W-1:0] dMemAddr;
   logic [DATA_W-1:0] dMemWdata;
   logic [DATA_W-1:0] dMemRdata;
   logic              dMemReady;
   logic              memRead;
   logic              memWrite;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;
   logic [DATA_W-1:0] memRdata;
   logic              memReady;
   logic [1:0]        owner;
   logic [CNT_W-1:0]  iCnt;
   logic [CNT_W-1:0]  dCnt;

   int nTests = 0;
   int nFail  = 0;
   int cyc    = 0;
   int strobeCyc = 0;
   int prevStrobeCyc = 0;
   int reqCyc = 0;

   txn_t expQ[$];

   logic [CNT_W-1:0]  expICnt;
   logic [CNT_W-1:0]  expDCnt;
   logic [DATA_W-1:0] expIRdata;
   logic [DATA_W-1:0] expDRdata;

   mem_bus_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_mem_read (iMemRead),
      .i_mem_addr (iMemAddr),
      .i_mem_rdata(iMemRdata),
      .i_mem_ready(iMemReady),
      .d_mem_read (dMemRead),
      .d_mem_write(dMemWrite),
      .d_mem_addr (dMemAddr),
      .d_mem_wdata(dMemWdata),
      .d_mem_rdata(dMemRdata),
      .d_mem_ready(dMemReady),
      .mem_read   (memRead),
      .mem_write  (memWrite),
      .mem_addr   (memAddr),
      .mem_wdata  (memWdata),
      .mem_rdata  (memRdata),
      .mem_ready  (memReady),
      .owner      (owner),
      .i_cnt      (iCnt),
      .d_cnt      (dCnt)
   );

   // Free-running clock and cycle counter used for latency checks.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // One comparison: counts it, and on a miss counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drives all cache-side request inputs at once.
   task automatic applyStimulus(input logic iRd, input logic dRd, input logic dWr,
                                input logic [ADDR_W-1:0] iAddr,
                                input logic [ADDR_W-1:0] dAddr,
                                input logic [DATA_W-1:0] dWdata);
      iMemRead  = iRd;
      dMemRead  = dRd;
      dMemWrite = dWr;
      iMemAddr  = iAddr;
      dMemAddr  = dAddr;
      dMemWdata = dWdata;
   endtask

   task automatic expectTxn(input logic who, input logic wr,
                            input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata,
                            input logic [DATA_W-1:0] rdata);
      txn_t t;
      t.who = who; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
      expQ.push_back(t);
   endtask

   // Memory responder: waits (bounded) for a strobe, checks it against the
   // queue head for lat cycles, answers with mem_ready on the last of them,
   // then checks the completion cycle and the following idle cycle. Ends at
   // the negedge of the idle cycle after DONE.
   task automatic serveTxn(input int lat);
      txn_t e;
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (memRead || memWrite) seen = 1'b1;
      end
      checkOutput("strobe_seen", seen, 1'b1);
      if (!seen || expQ.size() == 0) return;
      strobeCyc = cyc;
      e = expQ.pop_front();
      if (e.who) begin
         dMemAddr  = ADDR_W'($urandom);
         dMemWdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
         iMemAddr = ADDR_W'($urandom);
      end
      for (int k = 0; k < lat; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput("owner_serve", owner, e.who ? 2'b10 : 2'b01);
         checkOutput("mem_read", memRead, !e.wr);
         checkOutput("mem_write", memWrite, e.wr);
         checkOutput("mem_addr", memAddr, e.addr);
         if (e.wr) checkOutput("mem_wdata", memWdata, e.wdata);
         if (k == lat - 1) begin
            memReady = 1'b1;
            memRdata = e.rdata;
         end
      end
      @(negedge clk);
      memReady = 1'b0;
      memRdata = {$urandom, $urandom, $urandom, $urandom};
      if (e.who) begin
         if (expDCnt != '1) expDCnt++;
         if (!e.wr) expDRdata = e.rdata;
      end else begin
         if (expICnt != '1) expICnt++;
         expIRdata = e.rdata;
      end
      checkOutput("i_mem_ready_done", iMemReady, !e.who);
      checkOutput("d_mem_ready_done", dMemReady, e.who);
      checkOutput("strobes_done", {memRead, memWrite}, 2'b00);
      checkOutput("owner_done", owner, e.who ? 2'b10 : 2'b01);
      checkOutput("i_mem_rdata", iMemRdata, expIRdata);
      checkOutput("d_mem_rdata", dMemRdata, expDRdata);
      checkOutput("i_cnt", iCnt, expICnt);
      checkOutput("d_cnt", dCnt, expDCnt);
      if (e.who) begin
         dMemRead  = 1'b0;
         dMemWrite = 1'b0;
      end else begin
         iMemRead = 1'b0;
      end
      @(negedge clk);
      checkOutput("ready_after", {iMemReady, dMemReady}, 2'b00);
      checkOutput("owner_idle", owner, 2'b00);
   endtask

   initial begin
      logic seen;
      rst_n     = 1'b0;
      memReady  = 1'b0;
      memRdata  = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
      expICnt   = '0;
      expDCnt   = '0;
      expIRdata = '0;
      expDRdata = '0;

      #2;
      checkOutput("rst_strobes", {memRead, memWrite}, 2'b00);
      checkOutput("rst_mem_addr", memAddr, '0);
      checkOutput("rst_mem_wdata", memWdata, '0);
      checkOutput("rst_rdata", {iMemRdata, dMemRdata} == '0, 1'b1);
      checkOutput("rst_ready", {iMemReady, dMemReady}, 2'b00);
      checkOutput("rst_owner", owner, 2'b00);
      checkOutput("rst_cnt", {iCnt, dCnt}, '0);

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single I-cache read, three cycles of strobe before mem_ready.
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 28'h0000010, '0, '0);
      expectTxn(1'b0, 1'b0, 28'h0000010, '0, {16{8'hA5}});
      reqCyc = cyc;
      serveTxn(3);
      checkOutput("grant_latency", strobeCyc - reqCyc, 1);

      // Tie straight after reset: D first, then I. The second tie goes to D.
      applyStimulus(1'b1, 1'b1, 1'b0, 28'h0000030, 28'h0000040, '0);
      expectTxn(1'b1, 1'b0, 28'h0000040, '0, {4{32'hD0D0_0001}});
      expectTxn(1'b0, 1'b0, 28'h0000030, '0, {4{32'h1111_0001}});
      serveTxn(2);
      serveTxn(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 28'h0000031, 28'h0000041, '0);
      expectTxn(1'b1, 1'b0, 28'h0000041, '0, {4{32'hD0D0_0002}});
      expectTxn(1'b0, 1'b0, 28'h0000031, '0, {4{32'h1111_0002}});
      serveTxn(1);
      serveTxn(2);

      // D write-back leaves d_mem_rdata alone; read+write together is a write.
      applyStimulus(1'b0, 1'b0, 1'b1, '0, 28'h0000020, 128'h1234);
      expectTxn(1'b1, 1'b1, 28'h0000020, 128'h1234, {4{32'hBAD0_BAD0}});
      serveTxn(2);
      applyStimulus(1'b0, 1'b1, 1'b1, '0, 28'h0000050, 128'hCAFE_F00D);
      expectTxn(1'b1, 1'b1, 28'h0000050, 128'hCAFE_F00D, {4{32'hBAD1_BAD1}});
      serveTxn(1);

      // mem_ready while idle must not complete anything.
      memReady = 1'b1;
      memRdata = {4{32'hFFFF_0000}};
      @(negedge clk);
      memReady = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready_ignored", {iMemReady, dMemReady, memRead, memWrite}, 4'b0000);
      checkOutput("idle_cnt_hold", {iCnt, dCnt}, {expICnt, expDCnt});

      // Back-to-back I reads, each re-raised in the idle cycle after DONE.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 28'h0000100 + ADDR_W'(k), '0, '0);
         expectTxn(1'b0, 1'b0, 28'h0000100 + ADDR_W'(k), '0, {4{32'h7700_0000 + k}});
         prevStrobeCyc = strobeCyc;
         serveTxn(1);
         if (k > 0) checkOutput("b2b_spacing", strobeCyc - prevStrobeCyc, 3);
      end
      repeat (3) @(negedge clk);
      checkOutput("no_duplicate", {memRead, memWrite}, 2'b00);
      checkOutput("b2b_i_cnt", iCnt, expICnt);

      // Reset in the middle of a D write-back.
      applyStimulus(1'b0, 1'b0, 1'b1, '0, 28'h0000060, 128'h5555);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (memWrite) seen = 1'b1;
      end
      checkOutput("midrst_strobe_seen", seen, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_strobe", {memRead, memWrite}, 2'b00);
      checkOutput("midrst_owner", owner, 2'b00);
      checkOutput("midrst_ready", {iMemReady, dMemReady}, 2'b00);
      checkOutput("midrst_cnt", {iCnt, dCnt}, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
      expICnt   = '0;
      expDCnt   = '0;
      expIRdata = '0;
      expDRdata = '0;
      @(negedge clk);
      checkOutput("midrst_no_pulse", dMemReady, 1'b0);
      rst_n = 1'b1;

      // Normal service after the reset.
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 28'h0000070, '0);
      expectTxn(1'b1, 1'b0, 28'h0000070, '0, {4{32'h0C0F_FEE0}});
      serveTxn(2);

      // Saturation: preset d_cnt to all ones while idle, then complete a D read.
      force dut.d_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.d_cnt;
      expDCnt = 16'hFFFF;
      @(negedge clk);
      checkOutput("sat_preset", dCnt, 16'hFFFF);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 28'h0000080, '0);
      expectTxn(1'b1, 1'b0, 28'h0000080, '0, {4{32'h5A75_0001}});
      serveTxn(1);
      checkOutput("sat_hold", dCnt, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single off-chip memory port between I-cache miss reads and D-cache miss reads and write-backs.
- Sits between the two cache controllers and the memory model, underneath the pipeline top level.
- Serves one transaction at a time, round-robin on ties.
- Registers every memory-side output.
- Keeps saturating per-requester transaction counters for performance analysis.

Parameters:
- ADDR_W, 28, memory line address width.
- DATA_W, 128, memory line data width.
- CNT_W, 16, width of each transaction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_mem_read  input  1  I-cache line read request; held high until i_mem_ready is seen.
- i_mem_addr  input  ADDR_W  I-cache line address.
- i_mem_rdata  output  DATA_W  line returned to the I-cache.
- i_mem_ready  output  1  one-cycle completion pulse to the I-cache.
- d_mem_read  input  1  D-cache line read request.
- d_mem_write  input  1  D-cache write-back request.
- d_mem_addr  input  ADDR_W  D-cache line address.
- d_mem_wdata  input  DATA_W  D-cache write-back data.
- d_mem_rdata  output  DATA_W  line returned to the D-cache.
- d_mem_ready  output  1  one-cycle completion pulse to the D-cache.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1.
- mem_ready  input  1  memory completion, sampled only while serving.
- owner  output  2  current owner: 00 none, 01 I-cache, 10 D-cache.
- i_cnt  output  CNT_W  completed I-cache transactions, saturating.
- d_cnt  output  CNT_W  completed D-cache transactions, saturating.

Behaviour:
- Reset (async, rst_n=0) clears:
  - FSM to IDLE.
  - mem_read, mem_write, mem_addr, mem_wdata to 0.
  - i_mem_rdata, d_mem_rdata to 0; i_mem_ready, d_mem_ready to 0.
  - owner=00; i_cnt=d_cnt=0.
  - Round-robin pointer last=I, so D wins the first tie.
- Reset mid-transaction: strobes drop immediately with no completion pulse; the requester must re-issue after reset.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - pend_i = i_mem_read; pend_d = d_mem_read | d_mem_write.
  - Only one pending: grant it.
  - Both pending: grant the requester not equal to last.
  - On the grant edge, latch address, wdata and op into mem_addr, mem_wdata, mem_read, mem_write; set owner; update last.
  - d_mem_read and d_mem_write both high: write is performed and the read is ignored.
- SERVE_x:
  - Strobes are held constant until the first cycle mem_ready=1.
  - On that edge: strobes clear; for a read, mem_rdata is captured into x_mem_rdata; x_mem_ready is set; FSM goes to DONE.
  - No timeout; waits indefinitely.
- DONE:
  - Lasts exactly one cycle; x_mem_ready=1 only in this cycle.
  - Requests are ignored in DONE; the served requester must drop its request at the end of this cycle.
  - Next state is IDLE; owner returns to 00 on the DONE->IDLE edge.
- Counter increments on entry to DONE for the served requester; holds at 2^CNT_W-1.
- A D-cache write completion does not change d_mem_rdata.
- x_mem_rdata holds its value until that requester's next read completion.
- mem_ready during IDLE or DONE is ignored.
- Latency: request visible in cycle n (IDLE) -> strobe in n+1 -> with mem_ready in n+1, ready pulse in n+2 -> next grant earliest n+3.
- Input changes (address, wdata) after the grant edge have no effect on the current transaction.

Test Plan:
- Single I read: i_mem_read=1, addr=0x0000010 at cycle 1; mem_ready=1 in cycle 4 with rdata=0xA5..A5 -> mem_read high cycles 2-4, addr=0x0000010, i_mem_ready=1 in cycle 5 only, i_mem_rdata=0xA5..A5, i_cnt=1.
- Simultaneous requests after reset: i_mem_read=1 and d_mem_read=1 in the same cycle -> D served first (owner=10), then I (owner=01); next tie goes to D again since last=I.
- D write-back: d_mem_write=1, addr=0x0000020, wdata=0x1234 -> mem_write=1 with those values until mem_ready; d_mem_ready pulses once; d_mem_rdata unchanged; mem_read stays 0.
- Back-to-back I requests, each re-raised the cycle after its ready pulse, with D idle -> each served, exactly 3 cycles minimum between grants, no duplicate service, i_cnt increments by 1 per transaction.
- Reset mid-SERVE_D: rst_n=0 while mem_write=1 -> mem_write drops immediately, owner=00, no d_mem_ready pulse, counters 0; after release, a new request is served normally.
- Counter saturation: force d_cnt to 0xFFFF (CNT_W=16), complete one more D transaction -> d_cnt stays 0xFFFF.
